br_ptab: RTL and testbench

Prediction tag/address buffer between the dual-slot branch predictor and the branch unit. Each fetch group's prediction (pc, pred0/pred1 type and target) is enqueued at fetch in program order. The branch unit resolves the oldest group and the block compares the actual outcome against the stored prediction. On disagreement it raises a registered mispredict pulse with the redirect pc and flushes every younger entry.

---
 rtl/br_ptab.sv | 177 +++++++++++++++++
 tb/tb_br_ptab.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/br_ptab.sv
// br_ptab: prediction tag/address buffer between the dual-slot branch
// predictor and the branch unit.
//
// Each fetch group's prediction (word pc, per-slot type and target) is
// enqueued in program order. The branch unit resolves the oldest group; the
// stored prediction is compared against the actual outcome and, on
// disagreement, a registered one-cycle mispredict pulse is raised with the
// correct redirect pc while every younger entry is discarded.
//
// Optional feature: define BR_PTAB_STAT_EN to build the 32-bit performance
// counters (stat_br_cnt, stat_mis_cnt); otherwise both ports are tied to 0.
//
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   enq_*                      fetch-side prediction enqueue (valid/ready)
//   head_valid, head_pc        oldest buffered group
//   res_*                      branch-unit resolution of the oldest group
//   flush                      external flush (exception, ertn)
//   mispredict, redirect_pc    registered mispredict pulse + correct fetch pc
//   stat_br_cnt, stat_mis_cnt  performance counters
module br_ptab #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PW    = 30
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          enq_valid,
  output logic          enq_ready,
  input  logic [PW-1:0] enq_pc,
  input  logic [1:0]    enq_pred0_type,
  input  logic [1:0]    enq_pred1_type,
  input  logic [PW-1:0] enq_pred0_target,
  input  logic [PW-1:0] enq_pred1_target,
  output logic          head_valid,
  output logic [PW-1:0] head_pc,
  input  logic          res_valid,
  input  logic          res_slot,
  input  logic [1:0]    res_br_type,
  input  logic          res_jump,
  input  logic [PW-1:0] res_target,
  input  logic          flush,
  output logic          mispredict,
  output logic [PW-1:0] redirect_pc,
  output logic [31:0]   stat_br_cnt,
  output logic [31:0]   stat_mis_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [PW-1:0] pc;
    logic [1:0]    t0;
    logic [1:0]    t1;
    logic [PW-1:0] g0;
    logic [PW-1:0] g1;
  } ent_t;

  ent_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          mispredict_q, mispredict_d;
  logic [PW-1:0] redirect_pc_q, redirect_pc_d;

  ent_t          head;
  logic          push, pop, clear;
  logic          pred_tk, pred_slot, act_tk, mis_det;
  logic [PW-1:0] pred_tgt, redir;

  assign enq_ready   = (count_q != CNT_FULL);
  assign head_valid  = (count_q != '0);
  assign head        = mem_q[rd_ptr_q];
  assign head_pc     = head_valid ? head.pc : '0;
  assign mispredict  = mispredict_q;
  assign redirect_pc = redirect_pc_q;

  assign push = enq_valid && enq_ready;
  assign pop  = res_valid && head_valid;

  always_comb begin
    // Slot 0 wins when both slots carry a predicted branch.
    pred_tk   = (head.t0 != 2'b00) || (head.t1 != 2'b00);
    pred_slot = (head.t0 == 2'b00);
    pred_tgt  = pred_slot ? head.g1 : head.g0;
    act_tk    = (res_br_type != 2'b00) && res_jump;
    mis_det   = pop && ((pred_tk != act_tk) ||
                        (pred_tk && act_tk &&
                         ((pred_slot != res_slot) || (pred_tgt != res_target))));
    // Not-taken redirect resumes right after the wrongly predicted slot.
    redir     = act_tk ? res_target
                       : ({head.pc[PW-1:1], pred_slot} + PW'(1));
  end

  assign clear = flush || mis_det;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    mispredict_d  = mis_det && !flush;
    redirect_pc_d = (mis_det && !flush) ? redir : redirect_pc_q;
    if (clear) begin
      // Everything younger than the resolved group is wrong-path; the
      // coinciding enqueue is dropped along with it.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      mispredict_q  <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      mispredict_q  <= mispredict_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // Payload storage needs no reset: it is only observed through head_valid.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem_q[wr_ptr_q] <= '{pc: enq_pc, t0: enq_pred0_type, t1: enq_pred1_type,
                           g0: enq_pred0_target, g1: enq_pred1_target};
    end
  end

`ifdef BR_PTAB_STAT_EN
  logic [31:0] stat_br_q, stat_br_d;
  logic [31:0] stat_mis_q, stat_mis_d;

  always_comb begin
    stat_br_d  = stat_br_q;
    stat_mis_d = stat_mis_q;
    if (pop && (res_br_type != 2'b00)) stat_br_d  = stat_br_q + 32'd1;
    if (mispredict_d)                  stat_mis_d = stat_mis_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else begin
      stat_br_q  <= stat_br_d;
      stat_mis_q <= stat_mis_d;
    end
  end

  assign stat_br_cnt  = stat_br_q;
  assign stat_mis_cnt = stat_mis_q;
`else
  assign stat_br_cnt  = '0;
  assign stat_mis_cnt = '0;
`endif

  a_res_not_empty: assert property (@(posedge clk) disable iff (!rstn)
    res_valid |-> head_valid);
  a_res_slot_legal: assert property (@(posedge clk) disable iff (!rstn)
    (res_valid && head_valid) |-> !(!res_slot && head_pc[0]));

endmodule

// File: tb/tb_br_ptab.sv
// Self-checking bench for br_ptab: directed scenarios followed by random
// traffic, checked against a queue-based reference model via a scoreboard.
module tb_br_ptab;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned PW    = 30;

  logic          clk = 1'b0;
  logic          rstn;
  logic          enq_valid, enq_ready;
  logic [PW-1:0] enq_pc, enq_pred0_target, enq_pred1_target;
  logic [1:0]    enq_pred0_type, enq_pred1_type;
  logic          head_valid;
  logic [PW-1:0] head_pc;
  logic          res_valid, res_slot, res_jump;
  logic [1:0]    res_br_type;
  logic [PW-1:0] res_target;
  logic          flush, mispredict;
  logic [PW-1:0] redirect_pc;
  logic [31:0]   stat_br_cnt, stat_mis_cnt;

  br_ptab #(.DEPTH(DEPTH), .PW(PW)) dut (
    .clk(clk), .rstn(rstn),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_pc(enq_pc),
    .enq_pred0_type(enq_pred0_type), .enq_pred1_type(enq_pred1_type),
    .enq_pred0_target(enq_pred0_target), .enq_pred1_target(enq_pred1_target),
    .head_valid(head_valid), .head_pc(head_pc),
    .res_valid(res_valid), .res_slot(res_slot), .res_br_type(res_br_type),
    .res_jump(res_jump), .res_target(res_target), .flush(flush),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .stat_br_cnt(stat_br_cnt), .stat_mis_cnt(stat_mis_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  typedef struct {
    logic [PW-1:0] pc;
    logic [1:0]    t0, t1;
    logic [PW-1:0] g0, g1;
  } ment_t;
  ment_t         mq[$];
  bit            m_mis;
  logic [PW-1:0] m_redir;
  logic [31:0]   m_bc, m_mc;

  typedef struct {
    int            cyc;
    bit            hv, er, mis, chk_r;
    logic [PW-1:0] hpc, redir;
    logic [31:0]   bc, mc;
  } exp_t;
  exp_t sq[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: compares every expected snapshot due this cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sq.size() != 0 && sq[0].cyc <= cyc) begin
        e = sq.pop_front();
        chk("head_valid", 32'(head_valid), 32'(e.hv));
        chk("enq_ready", 32'(enq_ready), 32'(e.er));
        chk("head_pc", 32'(head_pc), 32'(e.hpc));
        chk("mispredict", 32'(mispredict), 32'(e.mis));
        if (e.chk_r) chk("redirect_pc", 32'(redirect_pc), 32'(e.redir));
`ifdef BR_PTAB_STAT_EN
        chk("stat_br_cnt", stat_br_cnt, e.bc);
        chk("stat_mis_cnt", stat_mis_cnt, e.mc);
`else
        chk("stat_br_cnt", stat_br_cnt, 32'd0);
        chk("stat_mis_cnt", stat_mis_cnt, 32'd0);
`endif
      end
    end
  end

  task automatic push_exp(int c, bit force_r);
    exp_t e;
    e.cyc   = c;
    e.hv    = (mq.size() != 0);
    e.er    = (mq.size() < DEPTH);
    e.hpc   = e.hv ? mq[0].pc : '0;
    e.mis   = m_mis;
    e.redir = m_redir;
    e.chk_r = m_mis || force_r;
    e.bc    = m_bc;
    e.mc    = m_mc;
    sq.push_back(e);
  endtask

  task automatic model_reset();
    mq.delete();
    m_mis = 0; m_redir = '0; m_bc = '0; m_mc = '0;
  endtask

  task automatic idle_in();
    enq_valid = 0; enq_pc = '0; enq_pred0_type = '0; enq_pred1_type = '0;
    enq_pred0_target = '0; enq_pred1_target = '0;
    res_valid = 0; res_slot = 0; res_br_type = '0; res_jump = 0;
    res_target = '0; flush = 0;
  endtask

  task automatic enq(logic [PW-1:0] pc, logic [1:0] t0, logic [PW-1:0] g0,
                     logic [1:0] t1, logic [PW-1:0] g1);
    enq_valid = 1; enq_pc = pc; enq_pred0_type = t0; enq_pred0_target = g0;
    enq_pred1_type = t1; enq_pred1_target = g1;
  endtask

  task automatic res(logic slot, logic [1:0] ty, logic jmp, logic [PW-1:0] tgt);
    res_valid = 1; res_slot = slot; res_br_type = ty; res_jump = jmp;
    res_target = tgt;
  endtask

  // Predicted (taken, slot, target) of a stored group: first slot with a type
  task automatic pred_of(ment_t h, output bit tk, output int s,
                         output logic [PW-1:0] tgt);
    logic [1:0] ty [2];
    logic [PW-1:0] tg [2];
    ty[0] = h.t0; ty[1] = h.t1; tg[0] = h.g0; tg[1] = h.g1;
    tk = 0; s = 0; tgt = '0;
    for (int k = 0; k < 2; k++)
      if (!tk && ty[k] != 2'b00) begin tk = 1; s = k; tgt = tg[k]; end
  endtask

  // Apply the driven inputs for one clock edge to the model and the DUT
  task automatic step();
    bit pop, push_ok, mis, ptk, atk;
    int ps;
    logic [PW-1:0] pt, rd;
    logic [PW+1:0] pkey, akey;
    ment_t h, n;
    push_ok = enq_valid && (mq.size() < DEPTH);
    pop     = res_valid && (mq.size() != 0);
    mis = 0; rd = m_redir;
    if (pop) begin
      h = mq[0];
      pred_of(h, ptk, ps, pt);
      atk  = (res_br_type != 2'b00) && res_jump;
      pkey = ptk ? {1'b1, 1'(ps), pt} : '0;
      akey = atk ? {1'b1, res_slot, res_target} : '0;
      mis  = (pkey != akey);
      rd   = atk ? res_target : ((h.pc & ~PW'(1)) + PW'(ps) + PW'(1));
      if (res_br_type != 2'b00) m_bc++;
    end
    if (flush) begin
      mq.delete(); m_mis = 0;
    end else if (mis) begin
      mq.delete(); m_mis = 1; m_redir = rd; m_mc++;
    end else begin
      m_mis = 0;
      if (pop) void'(mq.pop_front());
      if (push_ok) begin
        n.pc = enq_pc; n.t0 = enq_pred0_type; n.t1 = enq_pred1_type;
        n.g0 = enq_pred0_target; n.g1 = enq_pred1_target;
        mq.push_back(n);
      end
    end
    push_exp(cyc + 1, 0);
    @(posedge clk); #1;
    idle_in();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1);
  end

  initial begin
    bit ptk;
    int ps;
    logic [PW-1:0] pt;
    logic [1:0] t0, t1;
    logic [PW-1:0] pc;
    idle_in();
    rstn = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rstn = 1;
    push_exp(cyc, 1);

    // Correctly predicted taken branch in slot 0
    enq(30'h100, 2'b01, 30'h200, 2'b00, 30'h0); step();
    res(1'b0, 2'b01, 1'b1, 30'h200); step();
    step();

    // Unpredicted taken branch: mispredict, 3 younger groups dropped
    enq(30'h100, 2'b00, 30'h0, 2'b00, 30'h0); step();
    for (int i = 0; i < 3; i++) begin
      enq(30'h104 + 30'(i * 2), 2'b00, 30'h0, 2'b00, 30'h0); step();
    end
    res(1'b1, 2'b01, 1'b1, 30'h300); step();
    step();

    // Odd group predicted taken in slot 1, actually not taken
    enq(30'h101, 2'b00, 30'h0, 2'b01, 30'h400); step();
    res(1'b1, 2'b01, 1'b0, 30'h0); step();
    step();

    // Fill to DEPTH, then enqueue alongside a dequeue (no pass-through)
    for (int i = 0; i < DEPTH; i++) begin
      enq(30'h500 + 30'(i * 2), 2'b00, 30'h0, 2'b00, 30'h0); step();
    end
    enq(30'h7ff, 2'b00, 30'h0, 2'b00, 30'h0);
    res(1'b1, 2'b00, 1'b0, 30'h0); step();
    for (int i = 0; i < DEPTH - 1; i++) begin
      res(1'b1, 2'b00, 1'b0, 30'h0); step();
    end

    // Flush with enqueue and a mispredicting resolution
    enq(30'h600, 2'b10, 30'h650, 2'b00, 30'h0); step();
    enq(30'h602, 2'b00, 30'h0, 2'b00, 30'h0); step();
    enq(30'h604, 2'b00, 30'h0, 2'b00, 30'h0);
    res(1'b0, 2'b00, 1'b0, 30'h0);
    flush = 1; step();
    step();

    // Two more correctly handled branches: 5 branches, 2 mispredicts total
    enq(30'h700, 2'b00, 30'h0, 2'b10, 30'h780); step();
    enq(30'h702, 2'b00, 30'h0, 2'b00, 30'h0);
    res(1'b1, 2'b10, 1'b1, 30'h780); step();
    res(1'b0, 2'b11, 1'b0, 30'h0); step();
    step();

    // Random traffic
    for (int it = 0; it < 600; it++) begin
      if ($urandom_range(99) < 55) begin
        pc = 30'h100 + 30'($urandom_range(0, 255));
        t0 = ($urandom_range(2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        t1 = ($urandom_range(2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        if (pc[0]) t0 = 2'b00;
        enq(pc, t0, 30'h800 + 30'($urandom_range(0, 7)),
            t1, 30'h800 + 30'($urandom_range(0, 7)));
      end
      if (mq.size() != 0 && $urandom_range(1) == 1) begin
        pred_of(mq[0], ptk, ps, pt);
        if ($urandom_range(99) < 60) begin
          if (ptk) res(1'(ps), 2'($urandom_range(1, 3)), 1'b1, pt);
          else     res(1'b1, 2'($urandom_range(0, 3)), 1'b0, 30'h0);
        end else begin
          res(mq[0].pc[0] ? 1'b1 : 1'($urandom_range(1)),
              2'($urandom_range(0, 3)), 1'($urandom_range(1)),
              ($urandom_range(1) == 1) ? pt : 30'h800 + 30'($urandom_range(0, 7)));
        end
      end
      if (!res_valid && $urandom_range(99) < 4) flush = 1;
      step();
    end

    // Asynchronous reset mid-operation
    enq(30'h900, 2'b00, 30'h0, 2'b00, 30'h0); step();
    @(negedge clk); #1;
    rstn = 0;
    model_reset();
    push_exp(cyc + 1, 1);
    @(negedge clk); #1;
    @(negedge clk); #1;

    vectors++;
    if (sq.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got=%0d expected=0", sq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
